// File: rtl/bitwise_pkg.sv
// Shared types for the pipelined bitwise logic unit.
// Stage payload structs live in the modules because they depend on WIDTH.
package bitwise_pkg;

  typedef enum logic [1:0] {
    OP_XOR  = 2'd0,
    OP_OR   = 2'd1,
    OP_AND  = 2'd2,
    OP_XNOR = 2'd3
  } op_e;

endpackage

// File: rtl/bitwise_stage.sv
// One pipeline register slice: holds a valid bit plus a payload and loads both
// when enabled. The payload only updates on a valid beat so a parked result stays put.
module bitwise_stage #(
  parameter int unsigned DATA_W = 34
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              d_valid_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic              q_valid_o,
  output logic [DATA_W-1:0] q_data_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_valid_o <= 1'b0;
      q_data_o  <= '0;
    end else if (load_i) begin
      q_valid_o <= d_valid_i;
      if (d_valid_i) begin
        q_data_o <= d_data_i;
      end
    end
  end

endmodule

// File: rtl/bitwise_pipe.sv
// Pipelined WIDTH-bit XOR/OR/AND/XNOR unit with valid/ready on both sides,
// zero/parity flags and an occupancy count of the in-flight beats.
module bitwise_pipe
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [1:0]                 op_i,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [WIDTH-1:0]           b_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           result_o,
  output logic                       zero_o,
  output logic                       parity_o,
  output logic [$clog2(STAGES+1)-1:0] occupancy_o
);

  localparam int unsigned OCC_W  = $clog2(STAGES + 1);
  localparam int unsigned DATA_W = WIDTH + 2;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
  } stage_t;

  stage_t            head;
  logic [WIDTH-1:0]  op_result;
  logic [STAGES:0]   ready;
  logic [STAGES-1:0] valid_q;
  logic [DATA_W-1:0] data_q [STAGES];

  always_comb begin
    op_result = '0;
    case (op_e'(op_i))
      OP_XOR:  op_result = a_i ^ b_i;
      OP_OR:   op_result = a_i | b_i;
      OP_AND:  op_result = a_i & b_i;
      OP_XNOR: op_result = ~(a_i ^ b_i);
      default: op_result = '0;
    endcase
  end

  // Flags are taken once here, so later stages just carry them along.
  always_comb begin
    head.valid  = in_valid_i;
    head.result = op_result;
    head.zero   = (op_result == '0);
    head.parity = ^op_result;
  end

  // Resolved from the output end back, so a full pipe still accepts while draining.
  always_comb begin
    ready         = '0;
    ready[STAGES] = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = !valid_q[k] || ready[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              d_valid;
    logic [DATA_W-1:0] d_data;

    if (k == 0) begin : g_head
      assign d_valid = head.valid;
      assign d_data  = {head.result, head.zero, head.parity};
    end else begin : g_link
      assign d_valid = valid_q[k-1];
      assign d_data  = data_q[k-1];
    end

    bitwise_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (ready[k]),
      .d_valid_i (d_valid),
      .d_data_i  (d_data),
      .q_valid_o (valid_q[k]),
      .q_data_o  (data_q[k])
    );
  end

  always_comb begin
    occupancy_o = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy_o = occupancy_o + OCC_W'(valid_q[k]);
    end
  end

  assign in_ready_o  = ready[0] && rst_ni;
  assign out_valid_o = valid_q[STAGES-1];
  assign {result_o, zero_o, parity_o} = data_q[STAGES-1];

endmodule

// File: tb/tb_bitwise_pipe.sv
// Directed bench for bitwise_pipe: a scoreboard queue is filled on every input
// handshake and drained on every output handshake, in acceptance order.
module tb_bitwise_pipe;
  import bitwise_pkg::*;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 2;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             parity;
  logic [1:0]       occupancy;

  beat_t sb_q[$];
  int    checks     = 0;
  int    errors     = 0;
  int    cycle_cnt  = 0;
  int    accept_cnt = 0;
  int    emit_cnt   = 0;
  int    first_emit = -1;
  int    last_emit  = -1;

  always #5 clk = ~clk;

  bitwise_pipe #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .zero_o      (zero),
    .parity_o    (parity),
    .occupancy_o (occupancy)
  );

  function automatic beat_t modelBeat(input logic [1:0] op_v, input logic [WIDTH-1:0] a_v,
                                      input logic [WIDTH-1:0] b_v);
    beat_t            m;
    logic [WIDTH-1:0] r;
    case (op_v)
      2'd0:    r = a_v ^ b_v;
      2'd1:    r = a_v | b_v;
      2'd2:    r = a_v & b_v;
      default: r = ~(a_v ^ b_v);
    endcase
    m.result = r;
    m.zero   = (r == '0);
    m.parity = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      m.parity = m.parity ^ r[i];
    end
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Handshakes are sampled on the falling edge, inputs change just after the rising edge.
  task automatic advanceCycle();
    beat_t exp_b;
    @(negedge clk);
    if (out_valid && out_ready) begin
      emit_cnt++;
      if (first_emit < 0) first_emit = cycle_cnt;
      last_emit = cycle_cnt;
      checkBit("sb_has_entry", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        exp_b = sb_q.pop_front();
        checkOutput("result", result, exp_b.result);
        checkBit("zero", zero, exp_b.zero);
        checkBit("parity", parity, exp_b.parity);
      end
    end
    if (in_valid && in_ready) begin
      accept_cnt++;
      sb_q.push_back(modelBeat(op, a, b));
    end
    cycle_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input op_e op_v, input logic [WIDTH-1:0] a_v,
                               input logic [WIDTH-1:0] b_v);
    in_valid = 1'b1;
    op       = op_v;
    a        = a_v;
    b        = b_v;
    advanceCycle();
  endtask

  task automatic drainAll(input int budget);
    int n = 0;
    in_valid = 1'b0;
    while (sb_q.size() != 0 && n < budget) begin
      advanceCycle();
      n++;
    end
    checkOutput("drain_done", WIDTH'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int               base;
    int               idx;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] bp_a [3];
    logic [WIDTH-1:0] bp_b [3];

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = OP_XOR;
    a         = '0;
    b         = '0;
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 32'h0000_0005;
    b        = 32'h0000_0003;
    repeat (2) @(posedge clk);
    #1;
    checkBit("rst_in_ready", in_ready, 1'b0);
    checkBit("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_occupancy", WIDTH'(occupancy), 32'd0);
    checkBit("rst_zero", zero, 1'b0);
    checkBit("rst_parity", parity, 1'b0);

    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    checkBit("post_rst_in_ready", in_ready, 1'b1);
    repeat (3) advanceCycle();
    checkBit("post_rst_out_valid", out_valid, 1'b0);

    $display("[TB] ops with latency");
    applyStimulus(OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F);
    in_valid = 1'b0;
    checkBit("xor_lat0", out_valid, 1'b0);
    advanceCycle();
    checkBit("xor_lat1", out_valid, 1'b1);
    checkOutput("xor_value", result, 32'hF0F0_0F0F);
    advanceCycle();
    applyStimulus(OP_AND, 32'h0000_00F0, 32'h0000_000F);
    in_valid = 1'b0;
    advanceCycle();
    checkBit("and_zero_flag", zero, 1'b1);
    advanceCycle();
    applyStimulus(OP_XNOR, 32'h1234_5678, 32'h1234_5678);
    in_valid = 1'b0;
    advanceCycle();
    checkOutput("xnor_value", result, 32'hFFFF_FFFF);
    advanceCycle();
    applyStimulus(OP_OR, 32'h0000_0001, 32'h0000_0002);
    in_valid = 1'b0;
    advanceCycle();
    checkOutput("or_value", result, 32'h0000_0003);
    advanceCycle();
    checkOutput("ops_sb_empty", WIDTH'(sb_q.size()), 32'd0);

    $display("[TB] back-pressure");
    bp_a[0] = 32'h0000_0011; bp_b[0] = 32'h0000_0022;
    bp_a[1] = 32'h0000_0100; bp_b[1] = 32'h0000_0001;
    bp_a[2] = 32'h8000_0000; bp_b[2] = 32'h0000_0007;
    out_ready = 1'b0;
    base      = accept_cnt;
    idx       = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_OR, bp_a[idx], bp_b[idx]);
      if (accept_cnt - base > idx) idx++;
    end
    checkOutput("bp_accepted", WIDTH'(accept_cnt - base), 32'd2);
    checkOutput("bp_occupancy", WIDTH'(occupancy), 32'd2);
    checkBit("bp_in_ready", in_ready, 1'b0);
    checkBit("bp_out_valid", out_valid, 1'b1);
    held = result;
    checkOutput("bp_head_value", held, 32'h0000_0033);
    for (int i = 0; i < 2; i++) begin
      advanceCycle();
      checkOutput("bp_result_stable", result, held);
      checkBit("bp_valid_stable", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    checkBit("bp_release_in_ready", in_ready, 1'b1);
    advanceCycle();
    checkOutput("bp_third_accepted", WIDTH'(accept_cnt - base), 32'd3);
    checkOutput("bp_occ_after", WIDTH'(occupancy), 32'd2);
    drainAll(10);

    $display("[TB] streaming");
    out_ready  = 1'b1;
    first_emit = -1;
    base       = accept_cnt;
    idx        = emit_cnt;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(OP_XOR, WIDTH'(i), '0);
    end
    checkOutput("stream_accepted", WIDTH'(accept_cnt - base), 32'd8);
    drainAll(10);
    checkOutput("stream_emitted", WIDTH'(emit_cnt - idx), 32'd8);
    checkOutput("stream_no_gaps", WIDTH'(last_emit - first_emit), 32'd7);

    $display("[TB] full with drain and accept");
    out_ready = 1'b0;
    applyStimulus(OP_AND, 32'hFFFF_FFFF, 32'h0000_1234);
    applyStimulus(OP_XNOR, 32'h0000_0000, 32'h0000_0001);
    checkOutput("full_occupancy", WIDTH'(occupancy), 32'd2);
    checkBit("full_in_ready_stalled", in_ready, 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = OP_XOR;
    a         = 32'hCAFE_0000;
    b         = 32'h0000_BEEF;
    #1;
    checkBit("full_in_ready_draining", in_ready, 1'b1);
    advanceCycle();
    checkOutput("full_occ_kept", WIDTH'(occupancy), 32'd2);
    drainAll(10);

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(OP_OR, 32'h0000_00AA, 32'h0000_0055);
    applyStimulus(OP_XOR, 32'h0000_00AA, 32'h0000_0055);
    in_valid = 1'b0;
    checkOutput("mid_occ_before", WIDTH'(occupancy), 32'd2);
    rst_n = 1'b0;
    #1;
    checkBit("mid_out_valid", out_valid, 1'b0);
    checkOutput("mid_occupancy", WIDTH'(occupancy), 32'd0);
    checkBit("mid_in_ready", in_ready, 1'b0);
    checkOutput("mid_result", result, 32'd0);
    sb_q.delete();
    advanceCycle();
    rst_n = 1'b1;
    #1;
    checkBit("mid_release_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    applyStimulus(OP_AND, 32'h0F0F_0F0F, 32'h00FF_00FF);
    drainAll(10);
    repeat (3) advanceCycle();
    checkOutput("final_occupancy", WIDTH'(occupancy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
